// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous memory. Registered grant
// FSM with round-robin on contention, bounded bursts and per-port read return.

module mem_arbiter_rport #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_rd,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  rvalid,
  output logic [data_width-1:0] rdata
);
  logic                  pend;
  logic [data_width-1:0] hold;

  // Pending flag marks that memory returns this port's data next cycle;
  // hold keeps the last delivered word once the strobe drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      hold <= '0;
    end else begin
      pend <= acc_rd;
      if (pend) hold <= mem_rdata;
    end
  end

  assign rvalid = pend;
  assign rdata  = pend ? mem_rdata : hold;
endmodule

module mem_arbiter #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter int burst_max  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [data_width-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [data_width-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [data_width-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [data_width-1:0] m1_rdata,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_wr,
  input  logic [data_width-1:0] mem_rdata
);
  localparam int CW = $clog2(burst_max) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(burst_max - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [1:0]                 req, wr, gnt, acc, rvalid;
  logic [1:0][addr_width-1:0] addr;
  logic [1:0][data_width-1:0] wdata, rdata;
  logic                       own, rel;

  assign req   = {m1_req, m0_req};
  assign wr    = {m1_wr, m0_wr};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  assign gnt = {state == G1, state == G0};
  assign acc = gnt & req;
  assign own = (state == G1);

  // Memory sees only the granted port, and only while it is requesting.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc[0]) begin
      mem_addr  = addr[0];
      mem_wdata = wdata[0];
    end else if (acc[1]) begin
      mem_addr  = addr[1];
      mem_wdata = wdata[1];
    end
  end
  assign mem_wr = |(acc & wr);

  // Next-state: round-robin from IDLE, release on req drop or burst cap,
  // hand over directly to a waiting contender.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (req[0] && (!req[1] || last)) begin
          state_nxt = G0;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (req[1]) begin
          state_nxt = G1;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      G0, G1: begin
        rel = !req[own] || (acc[own] && cnt == CNT_LAST);
        if (rel) begin
          cnt_nxt = '0;
          if (req[~own]) begin
            state_nxt = own ? G0 : G1;
            last_nxt  = ~own;
          end else if (!req[own]) begin
            state_nxt = IDLE;
          end
        end else if (acc[own]) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state register; last=1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_rport
    mem_arbiter_rport #(.data_width(data_width)) u_rport (
      .clk      (clk),
      .rst      (rst),
      .acc_rd   (acc[k] & ~wr[k]),
      .mem_rdata(mem_rdata),
      .rvalid   (rvalid[k]),
      .rdata    (rdata[k])
    );
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand sequences for bursts/reset,
// and random traffic checked against a transaction-level reference model.

module tb_mem_arbiter;
  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  logic [15:0] tbmem [256];
  logic [15:0] ref_mem [256];

  mem_arbiter #(.data_width(16), .addr_width(8), .burst_max(BM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) tbmem[mem_addr] <= mem_wdata;
    mem_rdata <= tbmem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none), beats taken in current burst, last winner,
  // per-port queue of one read word expected next cycle.
  bit          mdl_on = 0;
  int          owner, beats, lastm;
  bit   [1:0]  rq_v;
  logic [15:0] rq_d [2];
  logic [15:0] hd   [2];

  task automatic mdl_reset();
    owner = -1; beats = 0; lastm = 1; rq_v = '0;
    rq_d[0] = '0; rq_d[1] = '0; hd[0] = '0; hd[1] = '0;
  endtask

  always @(negedge clk) begin
    if (mdl_on) begin
      bit r[2], w[2], a[2];
      logic [7:0]  ad[2];
      logic [15:0] wd[2], erd;
      logic [7:0]  e_addr;
      logic [15:0] e_wd;
      int nxt;
      r[0] = m0_req; r[1] = m1_req; w[0] = m0_wr; w[1] = m1_wr;
      ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_wdata; wd[1] = m1_wdata;
      a[0] = (owner == 0) && r[0];
      a[1] = (owner == 1) && r[1];
      e_addr = a[0] ? ad[0] : a[1] ? ad[1] : 8'h00;
      e_wd   = a[0] ? wd[0] : a[1] ? wd[1] : 16'h0;
      chk("mdl_gnt0", 32'(m0_gnt), 32'(owner == 0));
      chk("mdl_gnt1", 32'(m1_gnt), 32'(owner == 1));
      chk("mdl_mem_wr", 32'(mem_wr), 32'((a[0] && w[0]) || (a[1] && w[1])));
      chk("mdl_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mdl_mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("mdl_rvalid0", 32'(m0_rvalid), 32'(rq_v[0]));
      chk("mdl_rvalid1", 32'(m1_rvalid), 32'(rq_v[1]));
      for (int k = 0; k < 2; k++) begin
        erd = rq_v[k] ? rq_d[k] : hd[k];
        chk(k == 0 ? "mdl_rdata0" : "mdl_rdata1",
            32'(k == 0 ? m0_rdata : m1_rdata), 32'(erd));
        hd[k] = erd;
        rq_v[k] = a[k] && !w[k];
        rq_d[k] = ref_mem[ad[k]];
        if (a[k] && w[k]) ref_mem[ad[k]] = wd[k];
      end
      if (owner < 0) begin
        if (r[0] && r[1]) nxt = 1 - lastm;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
      end else begin
        if (a[owner]) beats++;
        if (!r[owner] || beats == BM) begin
          if (r[1-owner])    nxt = 1 - owner;
          else if (r[owner]) begin nxt = owner; beats = 0; end
          else               nxt = -1;
        end else nxt = owner;
      end
      if (nxt >= 0 && nxt != owner) begin lastm = nxt; beats = 0; end
      owner = nxt;
    end
  end

  task automatic drive(input bit r0, input bit w0, input logic [7:0] a0, input logic [15:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
  endtask

  task automatic do_reset();
    mdl_on = 0;
    #1 rst = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    mdl_on = 1;
  endtask

  typedef struct {
    bit r0; bit w0; logic [7:0] a0; logic [15:0] d0;
    bit r1; bit w1; logic [7:0] a1; logic [15:0] d1;
    bit g0; bit g1; bit mwr; logic [7:0] maddr; bit rv0; logic [15:0] rd0;
  } vec_t;

  vec_t tbl [11];
  int   rvcnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i]   = 16'hA000 + 16'(i) - 16'h000F;
      ref_mem[i] = tbmem[i];
    end
    rst = 1'b0;
    mdl_reset();
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    #3;
    chk("rst_gnt0", 32'(m0_gnt), 0);
    chk("rst_gnt1", 32'(m1_gnt), 0);
    chk("rst_rvalid0", 32'(m0_rvalid), 0);
    chk("rst_rvalid1", 32'(m1_rvalid), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rdata0", 32'(m0_rdata), 0);
    chk("rst_rdata1", 32'(m1_rdata), 0);
    do_reset();

    //           r0 w0 a0     d0      r1 w1 a1     d1        g0 g1 wr addr   rv0 rd0
    tbl[0]  = '{1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0000};
    tbl[1]  = '{1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h10, 0, 16'h0000};
    tbl[2]  = '{1, 0, 8'h11, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h11, 1, 16'hA001};
    tbl[3]  = '{1, 0, 8'h12, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h12, 1, 16'hA002};
    tbl[4]  = '{0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h00, 1, 16'hA003};
    tbl[5]  = '{0, 0, 8'h00, 16'h0, 1, 1, 8'h20, 16'h1234, 0, 0, 0, 8'h00, 0, 16'hA003};
    tbl[6]  = '{0, 0, 8'h00, 16'h0, 1, 1, 8'h20, 16'h1234, 0, 1, 1, 8'h20, 0, 16'hA003};
    tbl[7]  = '{1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0,    0, 1, 0, 8'h00, 0, 16'hA003};
    tbl[8]  = '{1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h20, 0, 16'hA003};
    tbl[9]  = '{0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h00, 1, 16'h1234};
    tbl[10] = '{0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 0, 16'h1234};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt0", i), 32'(m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].mwr));
      chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("tbl%0d_rvalid0", i), 32'(m0_rvalid), 32'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rdata0", i), 32'(m0_rdata), 32'(tbl[i].rd0));
    end

    // Both requesting from reset: port 0 first, then strict 4/4 alternation.
    do_reset();
    for (int t = 0; t < 17; t++) begin
      drive(1, 0, 8'(t), 16'h0, 1, 0, 8'(t + 100), 16'h0);
      @(negedge clk);
      chk($sformatf("alt%0d_gnt0", t), 32'(m0_gnt), 32'(t >= 1 && ((t - 1) / BM) % 2 == 0));
      chk($sformatf("alt%0d_gnt1", t), 32'(m1_gnt), 32'(t >= 1 && ((t - 1) / BM) % 2 == 1));
    end
    idle(3);

    // Port 0 alone for 9 beats: grant never drops across the burst cap.
    rvcnt = 0;
    for (int t = 0; t < 13; t++) begin
      drive(t < 10, 0, 8'(8'h40 + t), 16'h0, 0, 0, 8'h00, 16'h0);
      @(negedge clk);
      if (m0_rvalid) rvcnt++;
      if (t >= 1 && t <= 10) chk($sformatf("b9_%0d_gnt0", t), 32'(m0_gnt), 1);
    end
    chk("b9_rvalid_count", 32'(rvcnt), 9);

    // Reset while port 1 read is in flight.
    drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h30, 16'h0);
    @(negedge clk);
    drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h31, 16'h0);
    @(negedge clk);
    chk("rif_gnt1", 32'(m1_gnt), 1);
    @(posedge clk);
    #1;
    m1_req = 0;
    chk("rif_rvalid1_pre", 32'(m1_rvalid), 1);
    mdl_on = 0;
    #1 rst = 1'b0;
    #1;
    chk("rif_gnt0", 32'(m0_gnt), 0);
    chk("rif_gnt1_rst", 32'(m1_gnt), 0);
    chk("rif_rvalid1", 32'(m1_rvalid), 0);
    chk("rif_mem_wr", 32'(mem_wr), 0);
    mdl_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("post%0d_busy", t), 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 0);
    end
    mdl_on = 1;

    // Random traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 31)),
            16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 31)), 16'($urandom));
    end
    idle(3);
    @(negedge clk);
    mdl_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory (16-bit data, 8-bit address, one write enable) between two requesters.
  - Port 0: the processor datapath/control unit.
  - Port 1: a program loader/DMA master.
- Provides a registered request/grant handshake, bounded bursts and round-robin fairness.
- Returns read data with a per-port valid strobe.
- Sits between the requesters and the memory; the memory sees exactly one master per cycle.

Parameters:
- data_width, 16, width of write/read data.
- addr_width, 8, memory address width.
- burst_max, 4, maximum accepted beats per grant before forced re-arbitration (legal range 1..16).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- m0_req  input  1  port 0 request; held high while port 0 has beats to issue.
- m0_wr  input  1  port 0 beat is a write (1) or read (0).
- m0_addr  input  addr_width  port 0 address.
- m0_wdata  input  data_width  port 0 write data.
- m0_gnt  output  1  port 0 owns memory this cycle.
- m0_rvalid  output  1  port 0 read data valid.
- m0_rdata  output  data_width  port 0 read data.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_addr  output  addr_width  address to memory.
- mem_wdata  output  data_width  write data to memory.
- mem_wr  output  1  memory write enable.
- mem_rdata  input  data_width  memory read data, valid one cycle after the read address is presented.

Behaviour:
- Reset (rst=0, async): state=IDLE, last=1 (port 0 wins first), beat count=0, read-pending flags=0. All gnt, rvalid and mem_wr are 0; rdata, mem_addr and mem_wdata are 0.
- States:
  - IDLE: no grant.
  - G0: m0_gnt=1.
  - G1: m1_gnt=1.
- Grant outputs are decoded from registered state. At most one gnt is high in any cycle.
- Beat acceptance: a beat is accepted in a cycle where gnt_k=1 and req_k=1.
- Memory mux (combinational from the granted port):
  - mem_addr = addr_k; mem_wdata = wdata_k; mem_wr = gnt_k & req_k & wr_k.
  - In IDLE, or when the granted port has req low: mem_addr and mem_wdata = 0, mem_wr = 0.
- Read return: an accepted read beat on port k sets pend_k. On the next cycle rvalid_k=1 and rdata_k=mem_rdata (registered capture at that edge).
  - rvalid is a single-cycle pulse per read beat.
  - Back-to-back reads give back-to-back rvalid.
  - The rvalid of the last beat may coincide with the other port's grant; rvalid_k is independent of gnt_k.
  - rdata_k holds its last value when rvalid_k=0.
- Writes produce no response; a write completes in its accepted cycle.
- Latency: request from IDLE is granted on the next edge (req at cycle n, gnt at cycle n+1). Read data arrives one cycle after acceptance.
- IDLE transitions:
  - Only one req high: grant that port.
  - Both high: grant the port != last.
  - Neither: stay IDLE.
- Entering Gk sets last=k and count=0.
- In Gk, each accepted beat increments count. Release condition: req_k=0, or an accepted beat with count=burst_max-1. On release:
  - Other req high: go to G(other) directly, with no idle cycle.
  - Else req_k high (burst cap hit, no contender): stay Gk, count=0.
  - Else: IDLE.
- No release condition: stay Gk.
- Dropping req_k while granted is legal and releases on that edge. No beat is accepted in that cycle.
- burst_max=1: each port alternates every beat when both request continuously.
- count width = clog2(burst_max)+1; count never exceeds burst_max-1.
- Reset asserted mid-burst: grant and pend flags clear immediately (async). Any in-flight read produces no rvalid.

Test Plan:
- Port 0 only: req with 3 reads to addr 0x10..0x12 (memory preloaded 0xA001..0xA003) -> m0_gnt rises one cycle after req; m0_rvalid for 3 consecutive cycles with 0xA001, 0xA002, 0xA003; m1_gnt stays 0.
- Both req from IDLE after reset -> port 0 granted first. With burst_max=4 and both continuously requesting, grants alternate: 4 beats port 0, 4 beats port 1, with no idle cycle between them.
- Port 1 writes 0x1234 to 0x20, then port 0 reads 0x20 -> mem_wr high exactly one cycle with mem_addr=0x20; m0_rdata=0x1234 with m0_rvalid.
- Port 0 granted, drops req after 2 beats while port 1 requesting -> m1_gnt on the next edge, count restarts, no lost or duplicated rvalid for port 0's second read.
- Port 0 alone issues 9 beats with burst_max=4 -> m0_gnt stays high continuously; count wraps at 4 and 8; 9 rvalids delivered.
- rst pulled low while port 1 has a read in flight -> all gnt, rvalid and mem_wr go to 0 immediately. After release with no req: IDLE, and no spurious rvalid.
